// File: rtl/shifter_pkg.sv
// Shared types and helpers for the iterative shifter: FSM states, op-bit meanings, step clamp.
// No logic of its own; imported by iter_shifter.
// Backpressure: not applicable.
package shifter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic RIGHT = 1'b1;
    localparam logic LOGIC = 1'b1;

    // Operation captured at accept time and held for the whole iteration.
    typedef struct packed {
        logic right;
        logic fill;
        logic rotate;
    } op_t;

    function automatic int min_amt(input int rem, input int step);
        return (rem < step) ? rem : step;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: shift d by 0..STEP bits left/right with a fill bit or rotate.
// Latency: combinational.
// Backpressure: none.
module shift_step #(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 4,
    parameter int AMT_WIDTH  = $clog2(STEP + 1)
) (
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [AMT_WIDTH-1:0]  amt,
    input  logic                  right,
    input  logic                  fill,
    input  logic                  rotate,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0]   ext_fill;
    logic [2*DATA_WIDTH-1:0] wide;

    // The word is placed beside its own copy (rotate) or a fill word, so the
    // bits that move into the vacated positions come from the right source.
    always_comb begin
        ext_fill = '0;
        wide     = '0;
        q        = d;
        if (rotate) begin
            ext_fill = d;
        end else if (right) begin
            ext_fill = {DATA_WIDTH{fill}};
        end
        if (right) begin
            wide = {ext_fill, d} >> amt;
            q    = wide[DATA_WIDTH-1:0];
        end else begin
            wide = {d, ext_fill} << amt;
            q    = wide[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Iterative SLL/SRL/SRA unit shifting at most STEP bits per cycle; rotate ops with ITER_SHIFTER_ROTATE_EN.
// Latency: 1 + ceil(shift/STEP) cycles from accept to out_valid.
// Backpressure: result held in DONE until out_ready; no new request accepted until back in IDLE.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 5,
    parameter int STEP        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  d_in,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic                   arithOrLogic,
    input  logic                   leftOrRight,
`ifdef ITER_SHIFTER_ROTATE_EN
    input  logic                   rotate,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  d_out
);

    localparam int AMT_WIDTH = $clog2(STEP + 1);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  acc;
    logic [SHIFT_WIDTH-1:0] rem;
    op_t                    op;

    logic                   rot_req;
    logic [AMT_WIDTH-1:0]   amt;
    logic                   last;
    logic [DATA_WIDTH-1:0]  step_q;

`ifdef ITER_SHIFTER_ROTATE_EN
    assign rot_req = rotate;
`else
    assign rot_req = 1'b0;
`endif

    assign amt  = AMT_WIDTH'(min_amt(int'(rem), STEP));
    assign last = (int'(rem) <= STEP);

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP       (STEP),
        .AMT_WIDTH  (AMT_WIDTH)
    ) u_step (
        .d      (acc),
        .amt    (amt),
        .right  (op.right),
        .fill   (op.fill),
        .rotate (op.rotate),
        .q      (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d_out     <= '0;
            acc       <= '0;
            rem       <= '0;
            op        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc       <= d_in;
                        rem       <= shift;
                        op.right  <= (leftOrRight == RIGHT);
                        // Arithmetic fill is frozen here so partial results never feed back into it.
                        op.fill   <= (leftOrRight == RIGHT) && (arithOrLogic != LOGIC) && d_in[DATA_WIDTH-1];
                        op.rotate <= rot_req;
                        in_ready  <= 1'b0;
                        if (shift == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            d_out     <= d_in;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc <= step_q;
                    rem <= rem - SHIFT_WIDTH'(amt);
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        d_out     <= step_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
